// File: rtl/leitor_matriz.sv
// Raster frame-buffer reader: scans ALTURA x LARGURA addresses and streams pixels with valid/ready.
// Define LEITOR_CONTINUO_EN for an endless frame stream instead of one frame per iniciar.
module leitor_matriz #(
  parameter int LARGURA = 320,
  parameter int ALTURA  = 240
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  output logic [7:0] linha,
  output logic [8:0] coluna,
  output logic       escrever_na_matriz,
  input  logic [7:0] byte_lido,
  output logic [7:0] pixel,
  output logic       pixel_valido,
  input  logic       pixel_pronto,
  output logic       fim_de_quadro,
  output logic       ocupado
);
  localparam logic [8:0] COL_MAX = 9'(LARGURA - 1);
  localparam logic [7:0] LIN_MAX = 8'(ALTURA - 1);

  typedef enum logic [1:0] {OCIOSO, LENDO, ESVAZIANDO} estado_t;

  estado_t         estado_q, estado_d;
  logic [7:0]      linha_q, linha_d;
  logic [8:0]      coluna_q, coluna_d;
  logic            inicio_q, inicio_d;
  logic            voo_q, voo_d;
  logic            voo_fim_q, voo_fim_d;
  logic [1:0][7:0] buf_dado_q, buf_dado_d;
  logic [1:0]      buf_fim_q, buf_fim_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;

  logic       push, pop, ultimo, emite;
  logic [2:0] ocupacao;

  always_comb begin
    estado_d   = estado_q;
    linha_d    = linha_q;
    coluna_d   = coluna_q;
    inicio_d   = 1'b0;
    buf_dado_d = buf_dado_q;
    buf_fim_d  = buf_fim_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    pop      = (cnt_q != 2'd0) && pixel_pronto;
    push     = voo_q;
    ocupacao = 3'(cnt_q) + 3'(voo_q) - 3'(pop);
    ultimo   = (linha_q == LIN_MAX) && (coluna_q == COL_MAX);
    // The start cycle is a settle cycle: the first read goes out one cycle after iniciar is taken.
    emite    = (estado_q == LENDO) && !inicio_q && (ocupacao < 3'd2);

    voo_d     = emite;
    voo_fim_d = emite && ultimo;

    if (emite) begin
      if (coluna_q == COL_MAX) begin
        coluna_d = '0;
        linha_d  = ultimo ? '0 : linha_q + 8'd1;
      end else begin
        coluna_d = coluna_q + 9'd1;
      end
    end

    case (estado_q)
      OCIOSO: if (iniciar) begin
        estado_d = LENDO;
        inicio_d = 1'b1;
        linha_d  = '0;
        coluna_d = '0;
      end
      LENDO: begin
`ifndef LEITOR_CONTINUO_EN
        if (emite && ultimo) estado_d = ESVAZIANDO;
`endif
      end
      ESVAZIANDO: if (cnt_q == 2'd0 && !voo_q) estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase

    // Two-entry output buffer; the head slot is never overwritten while occupied.
    if (push) begin
      buf_dado_d[wr_ptr_q] = byte_lido;
      buf_fim_d[wr_ptr_q]  = voo_fim_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      linha_q    <= '0;
      coluna_q   <= '0;
      inicio_q   <= 1'b0;
      voo_q      <= 1'b0;
      voo_fim_q  <= 1'b0;
      buf_dado_q <= '0;
      buf_fim_q  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      linha_q    <= linha_d;
      coluna_q   <= coluna_d;
      inicio_q   <= inicio_d;
      voo_q      <= voo_d;
      voo_fim_q  <= voo_fim_d;
      buf_dado_q <= buf_dado_d;
      buf_fim_q  <= buf_fim_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign linha              = linha_q;
  assign coluna             = coluna_q;
  assign escrever_na_matriz = 1'b0;
  assign pixel              = buf_dado_q[rd_ptr_q];
  assign pixel_valido       = (cnt_q != 2'd0);
  assign fim_de_quadro      = pixel_valido && buf_fim_q[rd_ptr_q];
  assign ocupado            = (estado_q != OCIOSO);

endmodule

// File: tb/tb_leitor_matriz.sv
// Bench for leitor_matriz on a reduced 24x12 frame: the stream is checked against the raster
// index k, whose expected pixel is (k mod frame size) mod 256.
`timescale 1ns/1ps
module tb_leitor_matriz;
  localparam int L = 24;
  localparam int A = 12;
  localparam int N = L * A;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       pixel_pronto = 1'b0;
  logic [7:0] byte_lido = '0;
  logic [7:0] linha, pixel;
  logic [8:0] coluna;
  logic       escrever_na_matriz, pixel_valido, fim_de_quadro, ocupado;

  int vecs = 0;
  int errs = 0;
  bit wrap_seen = 0;

  leitor_matriz #(.LARGURA(L), .ALTURA(A)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
    .linha(linha), .coluna(coluna), .escrever_na_matriz(escrever_na_matriz),
    .byte_lido(byte_lido), .pixel(pixel), .pixel_valido(pixel_valido),
    .pixel_pronto(pixel_pronto), .fim_de_quadro(fim_de_quadro), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  // Frame buffer with a one-cycle synchronous read port.
  always @(posedge clock) byte_lido <= 8'((int'(linha) * L + int'(coluna)) % 256);

  task automatic scan_frame(input int quadros, input int pct, input int repulso, input int reset_em);
    int total, k, ciclos, primeiro, l_ant, c_ant, lw, cw, w;
    logic [7:0] px_ant;
    logic fim_ant;
    bit parado, pulso;
    total = quadros * N; k = 0; ciclos = 0; primeiro = -1; l_ant = 0; c_ant = 0;
    parado = 0; pulso = 0; px_ant = '0; fim_ant = 1'b0;
    @(negedge clock);
    vecs++;
    if (linha !== 8'd0 || coluna !== 9'd0) begin
      errs++; $display("FAIL start_addr got (%0d,%0d) want (0,0)", linha, coluna);
    end
    iniciar = 1'b1;
    while (k < total && ciclos < 20 * total + 50) begin
      @(negedge clock);
      ciclos++;
      iniciar = 1'b0;
      if (primeiro < 0 && pixel_valido) begin
        primeiro = ciclos - 1;
        vecs++;
        if (primeiro != 3) begin errs++; $display("FAIL latency got %0d edges want 3", primeiro); end
      end
      if (int'(linha) != l_ant || int'(coluna) != c_ant) begin
        cw = (c_ant + 1) % L;
        lw = (c_ant == L - 1) ? (l_ant + 1) % A : l_ant;
        vecs++;
        if (int'(linha) != lw || int'(coluna) != cw) begin
          errs++; $display("FAIL raster got (%0d,%0d) want (%0d,%0d)", linha, coluna, lw, cw);
        end
        if (l_ant == 0 && c_ant == L - 1 && linha == 8'd1 && coluna == 9'd0) wrap_seen = 1;
        l_ant = int'(linha); c_ant = int'(coluna);
      end
      if (parado) begin
        vecs++;
        if (!pixel_valido || pixel !== px_ant || fim_de_quadro !== fim_ant) begin
          errs++; $display("FAIL stall_hold got v=%0b px=%0d f=%0b want v=1 px=%0d f=%0b",
                           pixel_valido, pixel, fim_de_quadro, px_ant, fim_ant);
        end
      end
      if (pct == 100 && primeiro >= 0) begin
        vecs++;
        if (pixel_valido !== 1'b1) begin errs++; $display("FAIL full_rate bubble at pixel %0d got v=%0b want 1", k, pixel_valido); end
      end
      if (k == reset_em) begin
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({linha, coluna, pixel, pixel_valido, fim_de_quadro, ocupado} !== 28'd0) begin
          errs++; $display("FAIL reset_mid got l=%0d c=%0d px=%0d v=%0b f=%0b o=%0b want all 0",
                           linha, coluna, pixel, pixel_valido, fim_de_quadro, ocupado);
        end
        return;
      end
      if (k == repulso && !pulso) begin iniciar = 1'b1; pulso = 1; end
      pixel_pronto = ($urandom_range(99) < pct);
      if (pixel_valido) begin
        parado = !pixel_pronto; px_ant = pixel; fim_ant = fim_de_quadro;
        if (pixel_pronto) begin
          vecs++;
          if (pixel !== 8'((k % N) % 256) || fim_de_quadro !== 1'((k % N) == N - 1)) begin
            errs++; $display("FAIL pixel %0d got %0d/fim=%0b want %0d/fim=%0b", k, pixel,
                             fim_de_quadro, (k % N) % 256, (k % N) == N - 1);
          end
          k++;
        end
      end else parado = 0;
    end
    vecs++;
    if (k != total) begin errs++; $display("FAIL timeout got %0d pixels want %0d", k, total); end
`ifndef LEITOR_CONTINUO_EN
    w = 0;
    while (w < 3 && ocupado) begin @(negedge clock); w++; end
    vecs++;
    if (ocupado !== 1'b0 || w > 2) begin errs++; $display("FAIL ocupado_fall got o=%0b after %0d cycles want 0 within 2", ocupado, w); end
    vecs++;
    if (pixel_valido !== 1'b0) begin errs++; $display("FAIL extra_pixel got v=%0b want 0", pixel_valido); end
`else
    @(negedge clock);
    vecs++;
    if (ocupado !== 1'b1) begin errs++; $display("FAIL ocupado_cont got %0b want 1", ocupado); end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    vecs++; if (linha !== 8'd0) begin errs++; $display("FAIL rst_linha got %0d want 0", linha); end
    vecs++; if (coluna !== 9'd0) begin errs++; $display("FAIL rst_coluna got %0d want 0", coluna); end
    vecs++; if (pixel !== 8'd0) begin errs++; $display("FAIL rst_pixel got %0d want 0", pixel); end
    vecs++; if (pixel_valido !== 1'b0) begin errs++; $display("FAIL rst_valido got %0b want 0", pixel_valido); end
    vecs++; if (fim_de_quadro !== 1'b0) begin errs++; $display("FAIL rst_fim got %0b want 0", fim_de_quadro); end
    vecs++; if (ocupado !== 1'b0) begin errs++; $display("FAIL rst_ocupado got %0b want 0", ocupado); end
    vecs++; if (escrever_na_matriz !== 1'b0) begin errs++; $display("FAIL wr_en got %0b want 0", escrever_na_matriz); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    vecs++; if (ocupado !== 1'b0 || pixel_valido !== 1'b0) begin
      errs++; $display("FAIL idle_no_start got o=%0b v=%0b want 0 0", ocupado, pixel_valido);
    end
  endtask

  task automatic test_full_rate();
    scan_frame(1, 100, -1, -1);
  endtask

  task automatic test_backpressure();
    scan_frame(1, 55, -1, -1);
  endtask

  task automatic test_wrap();
    vecs++;
    if (wrap_seen !== 1'b1) begin errs++; $display("FAIL row_wrap got seen=%0b want (0,%0d)->(1,0) seen=1", wrap_seen, L - 1); end
  endtask

  task automatic test_ignore();
    scan_frame(1, 100, 100, -1);
  endtask

  task automatic test_reset_mid();
    scan_frame(1, 70, -1, 150);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      vecs++;
      if (pixel_valido !== 1'b0 || ocupado !== 1'b0) begin
        errs++; $display("FAIL post_reset got v=%0b o=%0b want 0 0", pixel_valido, ocupado);
      end
    end
    scan_frame(1, 100, -1, -1);
  endtask

  task automatic test_continuo();
    scan_frame(3, 80, -1, -1);
  endtask

  initial begin
    test_reset();
`ifndef LEITOR_CONTINUO_EN
    test_full_rate();
    test_backpressure();
    test_wrap();
    test_ignore();
    test_reset_mid();
`else
    test_continuo();
    test_wrap();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/leitor_matriz.md
LEITOR_MATRIZ -- requirements
Module: leitor_matriz

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter LARGURA, default 320: pixels per row.
REQ-003 Parameter ALTURA, default 240: rows per frame.
REQ-004 clock  input  1  single clock, rising-edge active.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 iniciar  input  1  single-cycle request to scan one frame.
REQ-007 linha  output  8  row address driven to the frame-buffer read port.
REQ-008 coluna  output  9  column address driven to the frame-buffer read port.
REQ-009 escrever_na_matriz  output  1  frame-buffer write enable; constant 0.
REQ-010 byte_lido  input  8  frame-buffer read data, valid exactly 1 cycle after the address.
REQ-011 pixel  output  8  streamed pixel value.
REQ-012 pixel_valido  output  1  pixel holds a valid value.
REQ-013 pixel_pronto  input  1  the consumer accepts the pixel this cycle.
REQ-014 fim_de_quadro  output  1  high together with pixel_valido on the last pixel of a frame.
REQ-015 ocupado  output  1  a scan is in progress.

Function
REQ-016 Transfer rule: a pixel transfers on a rising edge where pixel_valido=1 and pixel_pronto=1.
REQ-017 While pixel_valido=1 and pixel_pronto=0, pixel and fim_de_quadro SHALL hold stable.
REQ-018 States:
- OCIOSO: idle.
- LENDO: issuing reads.
- ESVAZIANDO: all addresses issued; draining.
REQ-019 OCIOSO->LENDO when iniciar=1 at a rising edge; iniciar is ignored in every other state.
REQ-020 Raster order: linha/coluna start at (0,0); coluna increments on each issued read; after LARGURA-1, coluna wraps to 0 and linha increments.
REQ-021 Last read: after the read of (ALTURA-1, LARGURA-1) is issued, the state SHALL go LENDO->ESVAZIANDO.
REQ-022 ESVAZIANDO->OCIOSO when the output buffer is empty and no read is in flight.
REQ-023 Output buffer: a 2-entry buffer SHALL capture byte_lido.
REQ-024 Read issue rule: a read is issued only in LENDO, and only when (buffered + in-flight - popping this cycle) < 2, so no data is ever lost.
REQ-025 Throughput: with pixel_pronto held high, one pixel per cycle is sustained after the initial latency.
REQ-026 Latency: the first pixel_valido SHALL be asserted on the 3rd rising edge after the edge that sampled iniciar.
REQ-027 ocupado=1 in LENDO and ESVAZIANDO, and 0 in OCIOSO.
REQ-028 linha and coluna SHALL be registered; they hold their value when no read is issued.
REQ-029 Width rule: address arithmetic SHALL never exceed LARGURA-1 or ALTURA-1, and no address outside the frame is ever driven.

Reset
REQ-030 reset_n=0 SHALL immediately force:
- state OCIOSO;
- linha=0, coluna=0;
- pixel=0, pixel_valido=0, fim_de_quadro=0, ocupado=0;
- buffer emptied.
REQ-031 On reset mid-scan, in-flight reads SHALL be discarded, and no pixel appears after reset_n is released until a new iniciar.

Configuration
REQ-032 Macro LEITOR_CONTINUO_EN defined: after the read of (ALTURA-1, LARGURA-1), the addresses SHALL wrap to (0,0) and stay in LENDO, giving an endless frame stream.
- fim_de_quadro still marks each frame's last pixel.
- ocupado stays 1 until reset.
REQ-033 Macro LEITOR_CONTINUO_EN undefined: one frame per iniciar, per REQ-021/REQ-022.

Verification
REQ-034 Full-rate scan: the RAM model returns (linha*320+coluna) mod 256; iniciar pulse with pixel_pronto=1 -> 76800 pixels in raster order, one per cycle.
- First pixel_valido on edge 3.
- fim_de_quadro only on pixel 76799.
- ocupado falls within 2 cycles after that pixel.
REQ-035 Backpressure: toggle pixel_pronto pseudo-randomly -> the same 76800-value sequence, with no loss or duplication, and pixel stable while stalled.
REQ-036 Wrap: check the read addresses around the row end -> (0,319) is followed by (1,0).
REQ-037 Ignore rule: iniciar re-pulsed at pixel 1000 -> no effect; the frame completes normally.
REQ-038 Reset mid-scan: reset_n low at pixel 5000 -> all outputs 0 next cycle. A new iniciar then restarts at (0,0).
REQ-039 With LEITOR_CONTINUO_EN: three consecutive frames -> fim_de_quadro on every 76800th pixel, and ocupado stays 1.
